// File: rtl/sgpio_tx_param_if.sv
// sgpio_tx_param_if: drive-status inputs and SGPIO outputs of the SGPIO transmitter.
// master: the status source, which drives ENABLE/ACT_IN/LOC_IN/FLT_IN and watches the SGPIO side.
// slave: the transmitter, which drives SGPIO_CK/LD/DATA, FRAME_DONE and FRAME_CNT.
interface sgpio_tx_param_if #(parameter int DRIVES = 36);
  logic              ENABLE;
  logic [DRIVES-1:0] ACT_IN;
  logic [DRIVES-1:0] LOC_IN;
  logic [DRIVES-1:0] FLT_IN;
  logic              SGPIO_CK;
  logic              SGPIO_LD;
  logic              SGPIO_DATA;
  logic              FRAME_DONE;
  logic [7:0]        FRAME_CNT;
  modport master (output ENABLE, ACT_IN, LOC_IN, FLT_IN,
                  input  SGPIO_CK, SGPIO_LD, SGPIO_DATA, FRAME_DONE, FRAME_CNT);
  modport slave  (input  ENABLE, ACT_IN, LOC_IN, FLT_IN,
                  output SGPIO_CK, SGPIO_LD, SGPIO_DATA, FRAME_DONE, FRAME_CNT);
endinterface

// File: rtl/sgpio_tx_param.sv
// sgpio_tx_param: parametrised SGPIO serializer of per-drive ACT/LOC/FLT status.
// Ports: SYSCLK, RESET (sync, active-high), bus (sgpio_tx_param_if.slave):
//   ENABLE, ACT_IN, LOC_IN, FLT_IN in; SGPIO_CK, SGPIO_LD, SGPIO_DATA, FRAME_DONE, FRAME_CNT out.
// Compile-time option ACT_STRETCH_EN: hold each ACT bit high for STRETCH_FRAMES extra frames.
module sgpio_tx_param #(
  parameter int DRIVES         = 36,
  parameter int BITS_PER_DRV   = 3,
  parameter int CLK_DIV        = 50,
  parameter int STRETCH_FRAMES = 4
) (
  input logic SYSCLK,
  input logic RESET,
  sgpio_tx_param_if.slave bus
);
  localparam int FB = DRIVES * BITS_PER_DRV;
  localparam int IW = FB > 1 ? $clog2(FB) : 1;
  localparam int PW = $clog2(CLK_DIV);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t            state_q;
  logic              en_m_q, en_s_q;
  logic [DRIVES-1:0] act_m_q, act_s_q, loc_m_q, loc_s_q, flt_m_q, flt_s_q, act_tx;
  logic [FB-1:0]     snap, shadow_q;
  logic [IW-1:0]     idx_q, idx_d;
  logic [PW-1:0]     pre_q;
  logic              ck_q, ld_q, data_q, done_q;
  logic [7:0]        cnt_q;
  logic              tick, fall, last, snap_go;
  // Synchronisers are deliberately not reset so a held ENABLE restarts a frame
  // on the first cycle after RESET drops.
  always_ff @(posedge SYSCLK) begin
    {en_s_q, en_m_q}   <= {en_m_q, bus.ENABLE};
    {act_s_q, act_m_q} <= {act_m_q, bus.ACT_IN};
    {loc_s_q, loc_m_q} <= {loc_m_q, bus.LOC_IN};
    {flt_s_q, flt_m_q} <= {flt_m_q, bus.FLT_IN};
  end
`ifdef ACT_STRETCH_EN
  for (genvar d = 0; d < DRIVES; d++) begin : g_st
    logic [3:0] st_q;
    always_ff @(posedge SYSCLK)
      if (RESET) st_q <= '0;
      else if (snap_go) st_q <= act_s_q[d] ? 4'(STRETCH_FRAMES) : st_q - 4'(st_q != 4'd0);
    assign act_tx[d] = act_s_q[d] | (st_q != 4'd0);
  end
`else
  localparam int unused_stretch = STRETCH_FRAMES;
  assign act_tx = act_s_q;
`endif
  for (genvar d = 0; d < DRIVES; d++) begin : g_snap
    assign snap[d*BITS_PER_DRV] = act_tx[d];
    if (BITS_PER_DRV > 1) begin : g_loc
      assign snap[d*BITS_PER_DRV+1] = loc_s_q[d];
    end
    if (BITS_PER_DRV > 2) begin : g_flt
      assign snap[d*BITS_PER_DRV+2] = flt_s_q[d];
    end
  end
  assign tick    = pre_q == PW'(CLK_DIV - 1);
  assign fall    = state_q == SHIFT && tick && ck_q;
  assign last    = idx_q == IW'(FB - 1);
  assign idx_d   = idx_q + 1'b1;
  // A new snapshot starts either from IDLE or back-to-back on the last falling edge.
  assign snap_go = en_s_q && (state_q == IDLE || (fall && last));
  always_ff @(posedge SYSCLK)
    if (RESET) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      ck_q     <= 1'b0;
      ld_q     <= 1'b0;
      data_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      done_q <= fall && last;
      cnt_q  <= cnt_q + 8'(fall && last);
      pre_q  <= (state_q == IDLE || tick) ? '0 : pre_q + 1'b1;
      ck_q   <= ck_q ^ tick;
      if (snap_go) begin
        state_q  <= SHIFT;
        idx_q    <= '0;
        shadow_q <= snap;
        ld_q     <= 1'b1;
        data_q   <= snap[0];
      end else if (fall && !last) begin
        idx_q  <= idx_d;
        data_q <= shadow_q[idx_d];
        ld_q   <= 1'b0;
      end else if (fall) begin
        state_q <= IDLE;
        ld_q    <= 1'b0;
        data_q  <= 1'b0;
      end
    end
  assign bus.SGPIO_CK   = ck_q;
  assign bus.SGPIO_LD   = ld_q;
  assign bus.SGPIO_DATA = data_q;
  assign bus.FRAME_DONE = done_q;
  assign bus.FRAME_CNT  = cnt_q;
endmodule

// File: tb/tb_sgpio_tx_param.sv
// tb_sgpio_tx_param: directed self-checking bench for sgpio_tx_param in three configurations.
module tb_sgpio_tx_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  sgpio_tx_param_if #(.DRIVES(36)) ifa ();
  sgpio_tx_param_if #(.DRIVES(8))  ifb ();
  sgpio_tx_param_if #(.DRIVES(1))  ifc ();
  sgpio_tx_param #(.DRIVES(36), .BITS_PER_DRV(3), .CLK_DIV(50), .STRETCH_FRAMES(4))
    u_a (.SYSCLK(clk), .RESET(rst), .bus(ifa.slave));
  sgpio_tx_param #(.DRIVES(8), .BITS_PER_DRV(3), .CLK_DIV(2), .STRETCH_FRAMES(4))
    u_b (.SYSCLK(clk), .RESET(rst), .bus(ifb.slave));
  sgpio_tx_param #(.DRIVES(1), .BITS_PER_DRV(1), .CLK_DIV(2), .STRETCH_FRAMES(4))
    u_c (.SYSCLK(clk), .RESET(rst), .bus(ifc.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receives one frame from instance B, starting at the next CK rise that carries LD.
  task automatic cap_b(output logic [23:0] s, output logic ok);
    logic pc;
    int n;
    s = '0;
    n = 0;
    pc = ifb.SGPIO_CK;
    for (int c = 0; c < 1000 && n < 24; c++) begin
      @(negedge clk);
      if (ifb.SGPIO_CK && !pc && (n > 0 || ifb.SGPIO_LD)) begin
        s = {s[22:0], ifb.SGPIO_DATA};
        n++;
      end
      pc = ifb.SGPIO_CK;
    end
    ok = (n == 24);
  endtask

  logic [23:0]  s;
  logic         ok, seen, pc, ldp, bad;
  logic [5:0]   exp_st;
  logic [107:0] st;
  logic [35:0]  act_led, loc_led, flt_led;
  logic [7:0]   cnt0, c255;
  int           t, n, ldc, nd;

  initial begin
    ifa.ENABLE = 0; ifa.ACT_IN = '0; ifa.LOC_IN = '0; ifa.FLT_IN = '0;
    ifb.ENABLE = 0; ifb.ACT_IN = '0; ifb.LOC_IN = '0; ifb.FLT_IN = '0;
    ifc.ENABLE = 0; ifc.ACT_IN = '0; ifc.LOC_IN = '0; ifc.FLT_IN = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ck", ifa.SGPIO_CK, 0);
    chk("rst_ld", ifa.SGPIO_LD, 0);
    chk("rst_data", ifa.SGPIO_DATA, 0);
    chk("rst_done", ifa.FRAME_DONE, 0);
    chk("rst_cnt", ifa.FRAME_CNT, 0);
    rst = 0;

    ifb.ACT_IN = 8'h81; ifb.LOC_IN = 8'h02; ifb.FLT_IN = 8'h40; ifb.ENABLE = 1;
    cap_b(s, ok);
    chk("b_frame_seen", ok, 1);
    chk("b_stream", s, 24'b100_010_000_000_000_000_001_100);
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ifb.FRAME_DONE) begin seen = 1; break; end
    end
    cnt0 = ifb.FRAME_CNT;
    t = 0;
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      t++;
      if (ifb.FRAME_DONE) begin seen = 1; break; end
    end
    chk("b_done_period", t, 96);
    chk("b_cnt_step", 8'(ifb.FRAME_CNT - cnt0), 1);

    ifb.ACT_IN = '0; ifb.LOC_IN = '0; ifb.FLT_IN = '0;
    repeat (93) @(posedge clk);
    #1 ifb.ACT_IN = 8'h08;
    @(posedge clk);
    #1 ifb.ACT_IN = 8'h00;
`ifdef ACT_STRETCH_EN
    exp_st = 6'b111110;
`else
    exp_st = 6'b100000;
`endif
    for (int f = 0; f < 6; f++) begin
      cap_b(s, ok);
      chk($sformatf("b_stretch_f%0d", f), {ok, s[14]}, {1'b1, exp_st[5-f]});
    end
    ifb.ENABLE = 0;

    ifa.ACT_IN = 36'hB_0000_0005; ifa.ENABLE = 1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ifa.SGPIO_LD) begin seen = 1; break; end
    end
    chk("a_ld_start", seen, 1);
    st = '0; t = 0; n = 0; ldc = 1; pc = ifa.SGPIO_CK; ldp = 1;
    for (int c = 0; c < 11000; c++) begin
      @(negedge clk);
      t++;
      if (ifa.SGPIO_CK && !pc && n < 108) begin st[n] = ifa.SGPIO_DATA; n++; end
      pc = ifa.SGPIO_CK;
      if (ifa.SGPIO_LD && !ldp) break;
      if (ifa.SGPIO_LD) ldc++;
      ldp = ifa.SGPIO_LD;
    end
    chk("a_frame_len", t, 10800);
    chk("a_ld_cycles", ldc, 100);
    chk("a_bit_count", n, 108);
    for (int d = 0; d < 36; d++) begin
      act_led[d] = st[3*d];
      loc_led[d] = st[3*d+1];
      flt_led[d] = st[3*d+2];
    end
    chk("a_act_led", act_led, 36'hB_0000_0005);
    chk("a_loc_led", loc_led, 0);
    chk("a_flt_led", flt_led, 0);

    cnt0 = ifa.FRAME_CNT;
    t = 0;
    repeat (10100) begin @(negedge clk); t++; end
    ifa.ENABLE = 0;
    seen = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      t++;
      if (ifa.FRAME_DONE) begin seen = 1; break; end
    end
    chk("a_drop_done_at", t, 10800);
    chk("a_drop_cnt", ifa.FRAME_CNT, 8'(cnt0 + 1));
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (ifa.SGPIO_CK || ifa.SGPIO_LD || ifa.SGPIO_DATA || ifa.FRAME_DONE) bad = 1;
    end
    chk("a_idle_quiet", bad, 0);
    chk("a_cnt_hold", ifa.FRAME_CNT, 8'(cnt0 + 1));

    ifa.ENABLE = 1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ifa.SGPIO_LD) begin seen = 1; break; end
    end
    chk("r_ld_start", seen, 1);
    repeat (3000) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("r_ck", ifa.SGPIO_CK, 0);
    chk("r_ld", ifa.SGPIO_LD, 0);
    chk("r_data", ifa.SGPIO_DATA, 0);
    chk("r_done", ifa.FRAME_DONE, 0);
    chk("r_cnt", ifa.FRAME_CNT, 0);
    rst = 0;
    @(negedge clk);
    chk("r_restart_ld", ifa.SGPIO_LD, 1);
    ifa.ENABLE = 0;

    ifc.ACT_IN = 1'b1; ifc.ENABLE = 1;
    nd = 0;
    c255 = '0;
    for (int c = 0; c < 1400 && nd < 256; c++) begin
      @(negedge clk);
      if (ifc.FRAME_DONE) begin
        nd++;
        if (nd == 255) c255 = ifc.FRAME_CNT;
      end
    end
    chk("c_cnt_255", c255, 255);
    chk("c_done_256", nd, 256);
    chk("c_cnt_wrap", ifc.FRAME_CNT, 0);
    ifc.ENABLE = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
